// File: rtl/pp_blk_scheduler.sv
// Frame-level raster block scheduler: one NPPC-wide block command per handshake.
// Optional stall counter output enabled by defining PP_BLK_SCHED_PERF_EN.
module pp_blk_scheduler #(
  parameter int NPPC  = 8,
  parameter int DIM_W = 16,
  parameter int PW_W  = $clog2(NPPC) + 1
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  output logic             ap_done,
  input  logic             ap_continue,
  output logic             ap_idle,
  output logic             ap_ready,
  input  logic [DIM_W-1:0] rows,
  input  logic [DIM_W-1:0] cols,
  output logic [DIM_W-1:0] nblk_per_row,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [DIM_W-1:0] blk_row,
  output logic [DIM_W-1:0] blk_col,
  output logic [PW_W-1:0]  blk_pxl_width,
  output logic             blk_eol,
  output logic             blk_eof
`ifdef PP_BLK_SCHED_PERF_EN
  , output logic [31:0]    perf_stall_cycles
`endif
);

  localparam int LOG2 = $clog2(NPPC);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_DONE} state_t;
  state_t state;

  logic [DIM_W-1:0] rows_q, cols_q, row_q, col_q, nblk_q;
  logic [PW_W-1:0]  last_w_q;
  logic [DIM_W:0]   cols_ext;
  logic [DIM_W-1:0] rem;
  logic             is_eol, is_eof;

  // One extra bit so cols near 2^DIM_W-1 round up without wrapping.
  assign cols_ext = {1'b0, cols_q} + (DIM_W+1)'(NPPC - 1);
  assign rem      = cols_q & DIM_W'(NPPC - 1);

  assign is_eol = blk_valid && (col_q == nblk_q - DIM_W'(1));
  assign is_eof = is_eol && (row_q == rows_q - DIM_W'(1));

  assign ap_idle       = (state == S_IDLE) & ~ap_start;
  assign nblk_per_row  = nblk_q;
  assign blk_row       = row_q;
  assign blk_col       = col_q;
  assign blk_eol       = is_eol;
  assign blk_eof       = is_eof;
  assign blk_pxl_width = is_eol ? last_w_q : PW_W'(NPPC);

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state     <= S_IDLE;
      blk_valid <= 1'b0;
      ap_done   <= 1'b0;
      ap_ready  <= 1'b0;
      rows_q    <= '0;
      cols_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      nblk_q    <= '0;
      last_w_q  <= '0;
    end else begin
      ap_ready <= 1'b0;
      case (state)
        S_IDLE: if (ap_start) begin
          rows_q   <= rows;
          cols_q   <= cols;
          ap_ready <= 1'b1;
          state    <= S_CALC;
        end
        S_CALC: begin
          nblk_q   <= DIM_W'(cols_ext >> LOG2);
          last_w_q <= (rem == '0) ? PW_W'(NPPC) : PW_W'(rem);
          row_q    <= '0;
          col_q    <= '0;
          if (rows_q == '0 || cols_q == '0) begin
            ap_done <= 1'b1;
            state   <= S_DONE;
          end else begin
            blk_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: if (blk_ready) begin
          if (is_eof) begin
            blk_valid <= 1'b0;
            ap_done   <= 1'b1;
            state     <= S_DONE;
          end else if (is_eol) begin
            col_q <= '0;
            row_q <= row_q + DIM_W'(1);
          end else begin
            col_q <= col_q + DIM_W'(1);
          end
        end
        S_DONE: if (ap_continue) begin
          ap_done <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PP_BLK_SCHED_PERF_EN
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n)
      perf_stall_cycles <= '0;
    else if (state == S_IDLE && ap_start)
      perf_stall_cycles <= '0;
    else if (blk_valid && !blk_ready && perf_stall_cycles != '1)
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
  end
`endif

endmodule
